bcd_scan_counter: RTL and testbench

//   N-digit decimal (BCD) event counter with time-multiplexed digit scan output.

---
 rtl/bcd_scan_counter.sv | 102 ++++++++++
 tb/tb_bcd_scan_counter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_counter.sv
// N-digit BCD event counter with a time-multiplexed, one-hot digit scan for a 7-segment driver.
// Count updates one cycle after inc/clr; bcd_out is combinational from registered state.
module bcd_scan_counter #(
  parameter int N_DIGITS = 4,
  parameter int SCAN_DIV = 1000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc,
  input  logic                  clr,
  output logic [4*N_DIGITS-1:0] count_bcd,
  output logic                  carry_out,
  output logic [3:0]            bcd_out,
  output logic [N_DIGITS-1:0]   digit_sel
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [4*N_DIGITS-1:0] count_q, count_d;
  logic                  carry_q, carry_d;
  logic [PW-1:0]         presc_q;
  logic [IW-1:0]         idx_q;
  logic [N_DIGITS-1:0]   sel_q;
  logic                  cy;

  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    cy      = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      cy = 1'b1;
      // Ripple the decimal carry from the least significant digit upward.
      for (int k = 0; k < N_DIGITS; k++) begin
        if (cy) begin
          if (count_q[4*k +: 4] == 4'd9) begin
            count_d[4*k +: 4] = 4'd0;
          end else begin
            count_d[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
            cy = 1'b0;
          end
        end
      end
      carry_d = cy;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      carry_q <= 1'b0;
      presc_q <= '0;
      idx_q   <= '0;
      sel_q   <= {{(N_DIGITS-1){1'b0}}, 1'b1};
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
      if (presc_q == PW'(SCAN_DIV - 1)) begin
        presc_q <= '0;
        idx_q   <= (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + IW'(1);
        sel_q   <= {sel_q[N_DIGITS-2:0], sel_q[N_DIGITS-1]};
      end else begin
        presc_q <= presc_q + PW'(1);
      end
    end
  end

  logic [N_DIGITS-1:0] blank;
  logic                hz;
  logic [3:0]          dig;
  logic                blk;

  // A digit is blank when it and every more significant digit are zero; digit 0 always shows.
  always_comb begin
    blank = '0;
    hz    = 1'b1;
    for (int k = N_DIGITS - 1; k > 0; k--) begin
      hz       = hz & (count_q[4*k +: 4] == 4'd0);
      blank[k] = hz;
    end
  end

  always_comb begin
    dig = 4'd0;
    blk = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        dig = count_q[4*k +: 4];
        blk = blank[k];
      end
    end
  end

  assign bcd_out   = (BLANK_LZ && blk) ? 4'hF : dig;
  assign count_bcd = count_q;
  assign carry_out = carry_q;
  assign digit_sel = sel_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Bench for bcd_scan_counter: table vectors, hand-built corner sequences and random traffic vs. an integer model.
module tb_bcd_scan_counter;
  localparam int N  = 4;
  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inc = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] count_bcd, count_nb;
  logic        carry_out, carry_nb;
  logic [3:0]  bcd_out, bcd_nb;
  logic [3:0]  digit_sel, sel_nb;

  bcd_scan_counter #(.N_DIGITS(N), .SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .inc(inc), .clr(clr),
    .count_bcd(count_bcd), .carry_out(carry_out), .bcd_out(bcd_out), .digit_sel(digit_sel)
  );

  bcd_scan_counter #(.N_DIGITS(N), .SCAN_DIV(SD), .BLANK_LZ(1'b0)) u_nb (
    .clk(clk), .rst_n(rst_n), .inc(inc), .clr(clr),
    .count_bcd(count_nb), .carry_out(carry_nb), .bcd_out(bcd_nb), .digit_sel(sel_nb)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int m_cnt = 0;
  int m_cyc = 0;
  bit m_carry = 1'b0;

  typedef struct {
    bit          inc;
    bit          clr;
    logic [15:0] cnt;
    bit          cy;
  } vec_t;
  vec_t tbl[8];

  function automatic int pow10(int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r = '0;
    for (int k = 0; k < N; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
    return r;
  endfunction

  function automatic logic [3:0] exp_digit(int v, int k, bit blank);
    if (blank && k > 0 && v < pow10(k)) return 4'hF;
    return 4'((v / pow10(k)) % 10);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int   idx = (m_cyc / SD) % N;
    logic ok = 1'b1;
    for (int k = 0; k < N; k++) if (count_bcd[4*k +: 4] > 4'd9) ok = 1'b0;
    chk("count", 32'(count_bcd), 32'(to_bcd(m_cnt)));
    chk("carry", 32'(carry_out), 32'(m_carry));
    chk("digit_sel", 32'(digit_sel), 32'(1 << idx));
    chk("bcd_out", 32'(bcd_out), 32'(exp_digit(m_cnt, idx, 1'b1)));
    chk("bcd_out_noblank", 32'(bcd_nb), 32'(exp_digit(m_cnt, idx, 1'b0)));
    chk("nibble_range", 32'(ok), 32'(1));
  endtask

  // Drive at the falling edge, advance the model on the rising edge, compare at the next falling edge.
  task automatic step(input bit i, input bit c);
    inc = i;
    clr = c;
    @(posedge clk);
    if (c) begin
      m_cnt = 0; m_carry = 1'b0;
    end else if (i) begin
      m_carry = (m_cnt == 9999);
      m_cnt = (m_cnt + 1) % 10000;
    end else begin
      m_carry = 1'b0;
    end
    m_cyc++;
    @(negedge clk);
    check_all();
    inc = 1'b0;
    clr = 1'b0;
  endtask

  task automatic load(input int v);
    step(1'b0, 1'b1);
    for (int i = 0; i < v; i++) step(1'b1, 1'b0);
  endtask

  task automatic align();
    for (int i = 0; i < 2 * N * SD && (m_cyc % (N * SD)) != 0; i++) step(1'b0, 1'b0);
    chk("align", 32'(m_cyc % (N * SD)), 32'(0));
  endtask

  task automatic scan_expect(input string name, input logic [15:0] eb, input logic [15:0] en);
    align();
    for (int j = 0; j < N; j++) begin
      for (int r = 0; r < SD; r++) begin
        chk({name, "_sel"}, 32'(digit_sel), 32'(1 << j));
        chk({name, "_bcd"}, 32'(bcd_out), 32'(eb[4*j +: 4]));
        chk({name, "_bcd_nb"}, 32'(bcd_nb), 32'(en[4*j +: 4]));
        step(1'b0, 1'b0);
      end
    end
    chk({name, "_sel_wrap"}, 32'(digit_sel), 32'(1));
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 16'h0001, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 16'h0002, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 16'h0002, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 16'h0000, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 16'h0001, 1'b0};
    tbl[5] = '{0, 1'b1, 16'h0000, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 16'h0001, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 16'h0002, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_count", 32'(count_bcd), 32'h0);
    chk("rst_carry", 32'(carry_out), 32'h0);
    chk("rst_sel", 32'(digit_sel), 32'h1);
    chk("rst_bcd", 32'(bcd_out), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].inc, tbl[i].clr);
      chk("tbl_count", 32'(count_bcd), 32'(tbl[i].cnt));
      chk("tbl_carry", 32'(carry_out), 32'(tbl[i].cy));
    end

    load(9);
    chk("cnt_0009", 32'(count_bcd), 32'h0009);
    step(1'b1, 1'b0);
    chk("cnt_0010", 32'(count_bcd), 32'h0010);
    for (int i = 0; i < 89; i++) step(1'b1, 1'b0);
    chk("cnt_0099", 32'(count_bcd), 32'h0099);
    step(1'b1, 1'b0);
    chk("cnt_0100", 32'(count_bcd), 32'h0100);

    load(123);
    chk("cnt_0123", 32'(count_bcd), 32'h0123);
    step(1'b1, 1'b1);
    chk("clr_inc_count", 32'(count_bcd), 32'h0000);
    chk("clr_inc_carry", 32'(carry_out), 32'h0);

    load(1234);
    scan_expect("scan1234", 16'h1234, 16'h1234);
    load(50);
    scan_expect("blank0050", 16'hFF50, 16'h0050);
    load(0);
    scan_expect("blank0000", 16'hFFF0, 16'h0000);

    load(9999);
    chk("cnt_9999", 32'(count_bcd), 32'h9999);
    step(1'b1, 1'b0);
    chk("wrap_count", 32'(count_bcd), 32'h0000);
    chk("wrap_carry", 32'(carry_out), 32'h1);
    step(1'b0, 1'b0);
    chk("wrap_carry_drop", 32'(carry_out), 32'h0);

    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));

    load(77);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count_bcd), 32'h0);
    chk("arst_sel", 32'(digit_sel), 32'h1);
    chk("arst_bcd", 32'(bcd_out), 32'h0);
    chk("arst_carry", 32'(carry_out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    m_cnt = 0; m_cyc = 0; m_carry = 1'b0;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
